// File: rtl/spi_link_pkg.sv
// Shared definitions for the 4-bit-command SPI link: command codes, frame field
// widths and the responder FSM state encoding.
package spi_link_pkg;

  localparam logic [3:0] CMD_READ  = 4'hA;
  localparam logic [3:0] CMD_WRITE = 4'hB;

  localparam int unsigned CMD_BITS   = 4;
  localparam int unsigned ADDR_BITS  = 4;
  localparam int unsigned DUMMY_BITS = 2;
  localparam int unsigned DATA_BITS  = 16;

  // Bit counter must reach DATA_BITS (16) so the write path can saturate there.
  localparam int unsigned CNT_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_ADDR    = 3'd2,
    ST_DUMMY   = 3'd3,
    ST_DATA_RD = 3'd4,
    ST_DATA_WR = 3'd5,
    ST_IGNORE  = 3'd6
  } spi_state_e;

  function automatic logic cmd_is_valid(input logic [CMD_BITS-1:0] cmd);
    return (cmd == CMD_READ) || (cmd == CMD_WRITE);
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Brings SCLK, CS_N and SDI into the clk_i domain and flags SCLK and CS_N edges.
// Reset state mimics an idle bus: sclk low, cs_n high, sdi low.
module spi_pin_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic spi_clk_i,
  input  logic spi_cs_n_i,
  input  logic spi_sdi_i,
  output logic cs_n_s_o,
  output logic sdi_s_o,
  output logic sclk_rise_o,
  output logic sclk_fall_o,
  output logic cs_rise_o,
  output logic cs_fall_o
);

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] sdi_sync_q;
  logic                   sclk_q;
  logic                   cs_n_q;
  logic                   sclk_s;
  logic                   cs_n_s;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      sdi_sync_q  <= '0;
      sclk_q      <= 1'b0;
      cs_n_q      <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk_i};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n_i};
      sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], spi_sdi_i};
      sclk_q      <= sclk_s;
      cs_n_q      <= cs_n_s;
    end
  end

  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign cs_n_s      = cs_sync_q[SYNC_STAGES-1];
  assign cs_n_s_o    = cs_n_s;
  assign sdi_s_o     = sdi_sync_q[SYNC_STAGES-1];
  assign sclk_rise_o = sclk_s & ~sclk_q;
  assign sclk_fall_o = ~sclk_s & sclk_q;
  assign cs_rise_o   = cs_n_s & ~cs_n_q;
  assign cs_fall_o   = ~cs_n_s & cs_n_q;

endmodule

// File: rtl/spi_slave_responder.sv
// SPI target: decodes cmd/addr/dummy/data frames against a 16 x 16-bit register file,
// with a registered system read port and a one-cycle write-event pulse.
module spi_slave_responder
  import spi_link_pkg::*;
#(
  parameter int unsigned          SYNC_STAGES = 2,
  parameter logic [DATA_BITS-1:0] RESET_VAL   = 16'h0000
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 spi_clk_i,
  input  logic                 spi_cs_n_i,
  input  logic                 spi_sdi_i,
  output logic                 spi_sdo_o,
  output logic                 spi_sdo_oe_o,
  input  logic [ADDR_BITS-1:0] sys_rd_addr_i,
  output logic [DATA_BITS-1:0] sys_rd_data_o,
  output logic                 wr_evt_vld_o,
  output logic [ADDR_BITS-1:0] wr_evt_addr_o,
  output logic [DATA_BITS-1:0] wr_evt_data_o,
  output logic                 busy_o
);

  localparam int unsigned NUM_REGS  = 1 << ADDR_BITS;
  localparam int unsigned PRIME_CNT = SYNC_STAGES + 1;
  localparam int unsigned PRIME_W   = $clog2(PRIME_CNT + 1);
  localparam int unsigned DIDX_W    = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0]   CMD_LAST   = CNT_W'(CMD_BITS - 1);
  localparam logic [CNT_W-1:0]   ADDR_LAST  = CNT_W'(ADDR_BITS - 1);
  localparam logic [CNT_W-1:0]   DUMMY_LAST = CNT_W'(DUMMY_BITS - 1);
  localparam logic [CNT_W-1:0]   DATA_FULL  = CNT_W'(DATA_BITS);
  localparam logic [PRIME_W-1:0] PRIME_DONE = PRIME_W'(PRIME_CNT);

  logic cs_n_s, sdi_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic rise_v, fall_v;

  spi_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PRIME_W-1:0]   prime_q, prime_d;
  logic                 primed;
  logic                 loaded_q, loaded_d;

  logic [CMD_BITS-1:0]  cmd_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [DATA_BITS-1:0] wbuf_q;
  logic [DATA_BITS-1:0] shifter_q, shifter_d;
  logic [DIDX_W-1:0]    wr_idx;
  logic                 enter_wr, enter_rd;
  logic                 commit;

  logic [DATA_BITS-1:0] regs_q [NUM_REGS];
  logic                 sdo_q, sdo_d;
  logic                 oe_q, oe_d;
  logic                 evt_vld_q;
  logic [ADDR_BITS-1:0] evt_addr_q;
  logic [DATA_BITS-1:0] evt_data_q;
  logic [DATA_BITS-1:0] sys_rd_q;

  spi_pin_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_pin_sync (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .spi_clk_i   (spi_clk_i),
    .spi_cs_n_i  (spi_cs_n_i),
    .spi_sdi_i   (spi_sdi_i),
    .cs_n_s_o    (cs_n_s),
    .sdi_s_o     (sdi_s),
    .sclk_rise_o (sclk_rise),
    .sclk_fall_o (sclk_fall),
    .cs_rise_o   (cs_rise),
    .cs_fall_o   (cs_fall)
  );

  // SCLK activity while deselected is treated as a glitch.
  assign rise_v = sclk_rise & ~cs_n_s;
  assign fall_v = sclk_fall & ~cs_n_s;

  // The synchronizer resets to an idle bus, so right after reset it can report a
  // false cs_fall; decoding is held off until the chain reflects the real pins.
  assign primed  = (prime_q == PRIME_DONE);
  assign prime_d = primed ? prime_q : prime_q + 1'b1;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      prime_q  <= '0;
      loaded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prime_q  <= prime_d;
      loaded_q <= loaded_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (cs_rise) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (primed) begin
            if (cs_fall)      state_d = ST_CMD;
            else if (!cs_n_s) state_d = ST_IGNORE;
          end
        end
        ST_CMD: begin
          if (rise_v) begin
            if (cnt_q == CMD_LAST) state_d = ST_ADDR;
            else                   cnt_d   = cnt_q + 1'b1;
          end
        end
        ST_ADDR: begin
          if (rise_v) begin
            if (cnt_q == ADDR_LAST) state_d = cmd_is_valid(cmd_q) ? ST_DUMMY : ST_IGNORE;
            else                    cnt_d   = cnt_q + 1'b1;
          end
        end
        ST_DUMMY: begin
          if (rise_v) begin
            if (cnt_q == DUMMY_LAST) state_d = (cmd_q == CMD_READ) ? ST_DATA_RD : ST_DATA_WR;
            else                     cnt_d   = cnt_q + 1'b1;
          end
        end
        ST_DATA_WR: begin
          if (rise_v && (cnt_q < DATA_FULL)) cnt_d = cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
    if (state_d != state_q) cnt_d = '0;
  end

  assign enter_wr = (state_d == ST_DATA_WR) && (state_q != ST_DATA_WR);
  assign enter_rd = (state_d == ST_DATA_RD) && (state_q != ST_DATA_RD);
  assign wr_idx   = DIDX_W'(DATA_BITS - 1) - cnt_q[DIDX_W-1:0];
  assign commit   = cs_rise && (state_q == ST_DATA_WR) && (cnt_q != '0);

  // Read shifter: first fall in DATA_RD snapshots the register, later falls shift out.
  always_comb begin
    shifter_d = shifter_q;
    loaded_d  = loaded_q;
    if (enter_rd) begin
      shifter_d = '0;
      loaded_d  = 1'b0;
    end else if ((state_q == ST_DATA_RD) && fall_v) begin
      if (!loaded_q) begin
        shifter_d = regs_q[addr_q];
        loaded_d  = 1'b1;
      end else begin
        shifter_d = {shifter_q[DATA_BITS-2:0], 1'b0};
      end
    end
    oe_d  = (state_q == ST_DATA_RD) && !cs_rise;
    sdo_d = oe_d & shifter_d[DATA_BITS-1];
  end

  always_ff @(posedge clk_i) begin
    if ((state_q == ST_CMD) && rise_v)  cmd_q  <= {cmd_q[CMD_BITS-2:0], sdi_s};
    if ((state_q == ST_ADDR) && rise_v) addr_q <= {addr_q[ADDR_BITS-2:0], sdi_s};
    if (enter_wr) begin
      wbuf_q <= '0;
    end else if ((state_q == ST_DATA_WR) && rise_v && (cnt_q < DATA_FULL)) begin
      wbuf_q[wr_idx] <= sdi_s;
    end
    shifter_q <= shifter_d;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
      sdo_q      <= 1'b0;
      oe_q       <= 1'b0;
      evt_vld_q  <= 1'b0;
      evt_addr_q <= '0;
      evt_data_q <= '0;
      sys_rd_q   <= '0;
    end else begin
      sdo_q     <= sdo_d;
      oe_q      <= oe_d;
      evt_vld_q <= commit;
      if (commit) begin
        regs_q[addr_q] <= wbuf_q;
        evt_addr_q     <= addr_q;
        evt_data_q     <= wbuf_q;
      end
      // Reads the pre-commit contents when a commit lands on the same address.
      sys_rd_q <= regs_q[sys_rd_addr_i];
    end
  end

  assign spi_sdo_o     = sdo_q;
  assign spi_sdo_oe_o  = oe_q;
  assign wr_evt_vld_o  = evt_vld_q;
  assign wr_evt_addr_o = evt_addr_q;
  assign wr_evt_data_o = evt_data_q;
  assign sys_rd_data_o = sys_rd_q;
  assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_slave_responder.sv
// Self-checking bench: SPI master driver, register-file reference model and a
// write-event scoreboard monitor running alongside the stimulus.
module tb_spi_slave_responder;
  import spi_link_pkg::*;

  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spi_clk = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_sdi = 1'b0;
  logic [3:0]  sys_rd_addr = 4'd0;
  logic        spi_sdo_o, spi_sdo_oe_o, wr_evt_vld_o, busy_o;
  logic [15:0] sys_rd_data_o, wr_evt_data_o;
  logic [3:0]  wr_evt_addr_o;

  int          checks = 0;
  int          errors = 0;
  int          oe_cnt = 0;
  logic [15:0] mreg [16];
  logic [19:0] evq [$];

  spi_slave_responder #(
    .SYNC_STAGES (2),
    .RESET_VAL   (16'h0000)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .spi_clk_i     (spi_clk),
    .spi_cs_n_i    (spi_cs_n),
    .spi_sdi_i     (spi_sdi),
    .spi_sdo_o     (spi_sdo_o),
    .spi_sdo_oe_o  (spi_sdo_oe_o),
    .sys_rd_addr_i (sys_rd_addr),
    .sys_rd_data_o (sys_rd_data_o),
    .wr_evt_vld_o  (wr_evt_vld_o),
    .wr_evt_addr_o (wr_evt_addr_o),
    .wr_evt_data_o (wr_evt_data_o),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic pulse(input logic b);
    spi_sdi = b;
    tick(HALF);
    spi_clk = 1'b1;
    tick(HALF);
    spi_clk = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mreg[i] = 16'h0000;
  endtask

  task automatic check_rd(input logic [3:0] a);
    sys_rd_addr = a;
    tick(1);
    chk($sformatf("sys_rd_a%0d", a), sys_rd_data_o, mreg[a]);
  endtask

  // One master frame of nclk SCLK periods. data holds the data-phase bits MSB first.
  task automatic do_frame(input logic [3:0] cmd, input logic [3:0] addr,
                          input int nclk, input logic [31:0] data);
    int          oe0, bad, nd;
    logic        b, eb;
    logic [15:0] snap, wv, mask, ones;
    snap = mreg[addr];
    oe0  = oe_cnt;
    bad  = 0;
    nd   = nclk - 10;
    wv   = 16'h0000;
    spi_cs_n = 1'b0;
    tick(HALF);
    for (int i = 0; i < nclk; i++) begin
      if (i < 4)                 b = cmd[3-i];
      else if (i < 8)            b = addr[7-i];
      else if (i < 10 || i > 41) b = 1'($urandom_range(0, 1));
      else                       b = data[41-i];
      spi_sdi = b;
      tick(HALF);
      if (cmd == CMD_READ && i >= 10) begin
        eb = (i < 26) ? snap[25-i] : 1'b0;
        if (spi_sdo_o !== eb || spi_sdo_oe_o !== 1'b1) bad++;
      end
      spi_clk = 1'b1;
      tick(HALF);
      spi_clk = 1'b0;
    end
    tick(HALF);
    if (cmd == CMD_WRITE && nd >= 1) begin
      ones = 16'hFFFF;
      mask = (nd >= 16) ? ones : ~(ones >> nd);
      wv   = data[31:16] & mask;
      evq.push_back({addr, wv});
    end
    spi_cs_n = 1'b1;
    tick(8);
    if (cmd == CMD_WRITE && nd >= 1) mreg[addr] = wv;
    if (cmd == CMD_READ && nd >= 1) chk($sformatf("miso_bits_a%0d", addr), bad, 0);
    chk($sformatf("oe_seen_cmd%0h", cmd), 32'(oe_cnt != oe0),
        32'(cmd == CMD_READ && nclk >= 10));
    chk("busy_after_frame", busy_o, 1'b0);
  endtask

  initial begin
    logic [3:0]  rc, ra;
    logic [7:0]  hdr;
    int          rn, oe0;
    logic [31:0] rd;

    fork
      forever begin
        @(negedge clk);
        if (spi_sdo_oe_o) oe_cnt++;
        if (wr_evt_vld_o) begin
          if (evq.size() == 0) begin
            chk("wr_evt_unexpected", {wr_evt_addr_o, wr_evt_data_o}, 20'h0);
            chk("wr_evt_unexpected_vld", 1'b1, 1'b0);
          end else begin
            chk("wr_evt", {wr_evt_addr_o, wr_evt_data_o}, evq.pop_front());
          end
        end
      end
    join_none

    model_reset();
    tick(3);
    chk("rst_sdo", spi_sdo_o, 1'b0);
    chk("rst_oe", spi_sdo_oe_o, 1'b0);
    chk("rst_evt_vld", wr_evt_vld_o, 1'b0);
    chk("rst_evt_addr", wr_evt_addr_o, 4'h0);
    chk("rst_evt_data", wr_evt_data_o, 16'h0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_sys_rd", sys_rd_data_o, 16'h0);
    rst_n = 1'b1;
    tick(10);

    // Directed: write/read 0xBEEF, short write, invalid cmd, aborts, over-length read.
    do_frame(CMD_WRITE, 4'd3, 26, 32'hBEEF_0000);
    sys_rd_addr = 4'd3;
    tick(1);
    chk("sys_rd_latency_beef", sys_rd_data_o, 16'hBEEF);
    do_frame(CMD_READ, 4'd3, 26, 32'h0);
    do_frame(CMD_WRITE, 4'd5, 18, 32'hA500_0000);
    check_rd(4'd5);
    do_frame(4'h7, 4'd2, 20, 32'hFFFF_FFFF);
    check_rd(4'd2);
    do_frame(CMD_WRITE, 4'd6, 6, 32'hFFFF_FFFF);
    check_rd(4'd6);
    do_frame(CMD_WRITE, 4'd9, 10, 32'hFFFF_FFFF);
    check_rd(4'd9);
    do_frame(CMD_WRITE, 4'd0, 26, 32'h8001_0000);
    do_frame(CMD_READ, 4'd0, 34, 32'h0);

    // Randomized frames, each preceded by SCLK glitches while deselected.
    for (int n = 0; n < 14; n++) begin
      repeat (2) begin
        spi_clk = 1'b1; tick(2);
        spi_clk = 1'b0; tick(2);
      end
      tick(HALF);
      rn = $urandom_range(0, 2);
      rc = (rn == 0) ? CMD_READ : (rn == 1) ? CMD_WRITE : 4'($urandom_range(0, 15));
      ra = 4'($urandom_range(0, 15));
      rd = $urandom;
      do_frame(rc, ra, $urandom_range(6, 34), rd);
      check_rd(4'($urandom_range(0, 15)));
    end

    // Reset during the ADDR phase with CS_N held low.
    hdr = {CMD_WRITE, 4'd3};
    spi_cs_n = 1'b0;
    tick(HALF);
    for (int i = 0; i < 6; i++) pulse(hdr[7-i]);
    rst_n = 1'b0;
    tick(2);
    model_reset();
    rst_n = 1'b1;
    tick(HALF);
    chk("busy_ignore_after_rst", busy_o, 1'b1);
    oe0 = oe_cnt;
    for (int i = 0; i < 20; i++) pulse(1'($urandom_range(0, 1)));
    tick(HALF);
    spi_cs_n = 1'b1;
    tick(8);
    chk("oe_after_rst_frame", 32'(oe_cnt != oe0), 32'd0);
    chk("busy_after_rst_frame", busy_o, 1'b0);
    check_rd(4'd3);
    do_frame(CMD_WRITE, 4'd4, 26, 32'h1234_0000);
    do_frame(CMD_READ, 4'd4, 26, 32'h0);
    check_rd(4'd4);

    tick(20);
    chk("evq_drained", evq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
